// File: rtl/scan_arbiter.sv
// scan_arbiter: shares one single-port scan RAM between the video readout,
// a host port and a fill-sweep (clear) engine. Fixed priority
// video > host > clear. The granted access is registered onto the RAM bus
// one cycle after the grant decision.
module scan_arbiter #(
   parameter int                ADDR_W   = 17,
   parameter int                DATA_W   = 8,
   parameter logic [ADDR_W-1:0] CLR_LAST = 17'h1FFFF
) (
   input  logic              clk25m,
   input  logic              reset,
   input  logic              v_req,
   input  logic [ADDR_W-1:0] v_addr,
   output logic              v_valid,
   input  logic              h_req,
   input  logic              h_we,
   input  logic [ADDR_W-1:0] h_addr,
   input  logic [DATA_W-1:0] h_wdata,
   output logic              h_ack,
   output logic              h_rvalid,
   input  logic              clr_start,
   input  logic [DATA_W-1:0] clr_value,
   output logic              clr_busy,
   output logic              clr_done,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   output logic              ram_re,
   input  logic [DATA_W-1:0] ram_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_DONE  = 2'd2
   } clr_state_t;

   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   // RAM bus and response strobes
   logic [ADDR_W-1:0] ram_addr_q;
   logic [DATA_W-1:0] ram_wdata_q;
   logic              ram_we_q;
   logic              ram_re_q;
   logic              rd_vid_q;
   logic              rd_host_q;
   logic              v_valid_q;
   logic              h_ack_q;
   logic              h_rvalid_q;
   logic              host_lock_q;

   // Clear engine
   clr_state_t        clr_state_q;
   logic [ADDR_W-1:0] clr_cnt_q;
   logic [DATA_W-1:0] clr_fill_q;
   logic              clr_busy_q;
   logic              clr_done_q;

   // Grant decision for the current cycle
   logic host_elig;
   logic gnt_v;
   logic gnt_h;
   logic gnt_c;

   // Read data flows straight from the RAM to its consumers; the arbiter only
   // times its validity, so the bus is intentionally not consumed here.
   logic unused_rdata;
   assign unused_rdata = ^ram_rdata;

   // A host request is issued once per assertion of h_req: after its grant
   // the port stays locked (covering the h_ack cycle) until h_req is released.
   assign host_elig = h_req && !host_lock_q;
   assign gnt_v     = v_req;
   assign gnt_h     = !v_req && host_elig;
   assign gnt_c     = !v_req && !host_elig && (clr_state_q == ST_CLEAR);

   // Register the granted access onto the RAM bus and time the response strobes
   always_ff @(posedge clk25m) begin
      if (reset) begin
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         ram_we_q    <= 1'b0;
         ram_re_q    <= 1'b0;
         rd_vid_q    <= 1'b0;
         rd_host_q   <= 1'b0;
         v_valid_q   <= 1'b0;
         h_ack_q     <= 1'b0;
         h_rvalid_q  <= 1'b0;
         host_lock_q <= 1'b0;
      end else begin
         ram_we_q   <= 1'b0;
         ram_re_q   <= 1'b0;
         h_ack_q    <= gnt_h;
         rd_vid_q   <= gnt_v;
         rd_host_q  <= gnt_h && !h_we;
         v_valid_q  <= rd_vid_q;
         h_rvalid_q <= rd_host_q;

         if (gnt_v) begin
            ram_re_q   <= 1'b1;
            ram_addr_q <= v_addr;
         end else if (gnt_h) begin
            ram_re_q   <= !h_we;
            ram_we_q   <= h_we;
            ram_addr_q <= h_addr;
            if (h_we) begin
               ram_wdata_q <= h_wdata;
            end
         end else if (gnt_c) begin
            ram_we_q    <= 1'b1;
            ram_addr_q  <= clr_cnt_q;
            ram_wdata_q <= clr_fill_q;
         end

         if (gnt_h) begin
            host_lock_q <= 1'b1;
         end else if (!h_req) begin
            host_lock_q <= 1'b0;
         end
      end
   end

   // Clear sweep FSM: counter only advances on cycles the sweep actually owns the RAM
   always_ff @(posedge clk25m) begin
      if (reset) begin
         clr_state_q <= ST_IDLE;
         clr_cnt_q   <= '0;
         clr_fill_q  <= '0;
         clr_busy_q  <= 1'b0;
         clr_done_q  <= 1'b0;
      end else begin
         clr_done_q <= 1'b0;
         case (clr_state_q)
            ST_IDLE: begin
               if (clr_start) begin
                  clr_state_q <= ST_CLEAR;
                  clr_cnt_q   <= '0;
                  clr_fill_q  <= clr_value;
                  clr_busy_q  <= 1'b1;
               end
            end
            ST_CLEAR: begin
               if (gnt_c) begin
                  if (clr_cnt_q == CLR_LAST) begin
                     clr_state_q <= ST_DONE;
                     clr_busy_q  <= 1'b0;
                  end else begin
                     clr_cnt_q <= clr_cnt_q + ADDR_ONE;
                  end
               end
            end
            ST_DONE: begin
               clr_done_q  <= 1'b1;
               clr_state_q <= ST_IDLE;
            end
            default: begin
               clr_state_q <= ST_IDLE;
               clr_busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;
   assign ram_we    = ram_we_q;
   assign ram_re    = ram_re_q;
   assign v_valid   = v_valid_q;
   assign h_ack     = h_ack_q;
   assign h_rvalid  = h_rvalid_q;
   assign clr_busy  = clr_busy_q;
   assign clr_done  = clr_done_q;

endmodule

// File: doc/scan_arbiter.md
SCAN_ARBITER -- requirements
Module: scan_arbiter

Interface
REQ-001 Parameter ADDR_W, default 17, scan RAM address width.
REQ-002 Parameter DATA_W, default 8, scan RAM data width.
REQ-003 Parameter CLR_LAST, default 17'h1FFFF, last address written by clear engine.
REQ-004 clk25m  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 v_req  input  1  video readout read request, valid per cycle.
REQ-007 v_addr  input  ADDR_W  video read address.
REQ-008 v_valid  output  1  video read data valid on ram_rdata.
REQ-009 h_req  input  1  host request, held until h_ack.
REQ-010 h_we  input  1  host write (1) / read (0).
REQ-011 h_addr  input  ADDR_W  host address.
REQ-012 h_wdata  input  DATA_W  host write data.
REQ-013 h_ack  output  1  one-cycle pulse, host request issued to RAM.
REQ-014 h_rvalid  output  1  host read data valid on ram_rdata.
REQ-015 clr_start  input  1  pulse, begin clear sweep.
REQ-016 clr_value  input  DATA_W  fill value, sampled on accepted clr_start.
REQ-017 clr_busy  output  1  clear sweep in progress.
REQ-018 clr_done  output  1  one-cycle pulse at sweep completion.
REQ-019 ram_addr  output  ADDR_W  registered RAM address.
REQ-020 ram_wdata  output  DATA_W  registered RAM write data.
REQ-021 ram_we  output  1  registered RAM write strobe.
REQ-022 ram_re  output  1  registered RAM read strobe.
REQ-023 ram_rdata  input  DATA_W  RAM read data, valid one cycle after ram_re.

Function
REQ-024 Arbitration each cycle SHALL be fixed priority: video > host > clear; at most one grant per cycle.
REQ-025 Grant decided from current-cycle inputs; ram_addr/ram_wdata/ram_we/ram_re SHALL register the granted access at the next edge (1-cycle issue latency).
REQ-026 Idle cycle (no grant): ram_we=0, ram_re=0, ram_addr/ram_wdata hold previous values.
REQ-027 Video grant: ram_re=1, ram_addr=v_addr; v_valid SHALL assert exactly one cycle after that ram_re cycle (2 cycles after v_req).
REQ-028 Host grant: h_ack SHALL pulse in the same cycle ram_re/ram_we carry the host access.
REQ-029 h_req SHALL be ignored in any cycle h_ack=1, so a held request is not issued twice.
REQ-030 Host read: h_rvalid SHALL assert one cycle after the host ram_re cycle; host write produces no h_rvalid.
REQ-031 Clear FSM states IDLE, CLEAR, DONE; IDLE->CLEAR on clr_start, counter=0, fill latched.
REQ-032 In CLEAR, each clear grant SHALL write fill to counter address, then counter increments; clr_busy=1 throughout CLEAR.
REQ-033 Write to CLR_LAST SHALL move CLEAR->DONE; DONE pulses clr_done for one cycle, returns to IDLE.
REQ-034 clr_start in CLEAR or DONE SHALL be ignored; fill value unchanged mid-sweep.
REQ-035 Clear counter SHALL not advance on cycles denied to video or host; no address skipped or repeated.
REQ-036 v_req and h_req simultaneous: video issued; host waits, h_ack later; no starvation guarantee for host beyond video idle cycles.
REQ-037 Counter width ADDR_W; CLR_LAST=0 SHALL produce a single write then DONE.

Reset
REQ-038 On reset: ram_we=0, ram_re=0, ram_addr=0, ram_wdata=0, v_valid=0, h_ack=0, h_rvalid=0, clr_busy=0, clr_done=0, FSM=IDLE, counter=0.
REQ-039 Reset during CLEAR SHALL abort sweep without clr_done; reset during pending host request drops it (no h_ack).

Verification
REQ-040 v_req=1 v_addr=0x00123 one cycle -> next cycle ram_re=1 ram_addr=0x00123, following cycle v_valid=1.
REQ-041 v_req and h_req(write, addr 0x00010, data 0x5A) together, v_req drops after 3 cycles -> host write issued cycle 4 with h_ack=1, exactly once.
REQ-042 CLR_LAST=15, clr_start with clr_value=0xFF, no other traffic -> 16 writes addr 0..15 data 0xFF on consecutive cycles, clr_done one cycle after last write.
REQ-043 Clear running, inject alternating v_req cycles -> writes interleave, addresses still contiguous 0..CLR_LAST, total count CLR_LAST+1.
REQ-044 Host read addr 0x00020 held 5 cycles -> single ram_re, single h_ack, h_rvalid one cycle later.
REQ-045 Reset asserted mid-sweep at counter=7 -> all outputs at reset values next cycle, clr_done never pulses, fresh clr_start restarts at address 0.
